counter_arbiter: RTL and testbench
==================================

COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 The block SHALL have parameter CW, default 4, giving the counter and init width in bits.
REQ-002 The block SHALL have parameter NREQ, default 3, giving the requester count; the design is verified only at 3.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port req, input, NREQ bits: one request line per requester, held high for the duration of a job.
REQ-006 Port init0, input, CW bits: start value for requester 0; ports init1 and init2 SHALL do the same for requesters 1 and 2.
REQ-007 Port grant, output, NREQ bits: one-hot or zero, naming the current owner of the shared counter.
REQ-008 Port owner, output, 2 bits: binary index of the current or most recent owner.
REQ-009 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-010 Port done, output, 1 bit: single-cycle pulse at normal job completion.
REQ-011 Port count, output, CW bits: the shared counter value.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, RUN and DONE, all registered.
REQ-013 IDLE with any req high SHALL arbitrate round-robin, searching from (last+1) mod 3, and at the edge set grant one-hot, set owner, and enter LOAD.
REQ-014 IDLE with no req SHALL hold all outputs, with grant=0.
REQ-015 LOAD SHALL write the owner's init value into count at the edge and enter RUN.
REQ-016 RUN with count equal to all-ones SHALL enter DONE; otherwise count SHALL increment by 1.
REQ-017 Count SHALL never wrap during a job; width is CW, and count+1 is taken modulo 2^CW.
REQ-018 DONE SHALL assert done=1 for exactly that cycle with grant still asserted, then clear grant, set last=owner, and enter IDLE.
REQ-019 Latency: with req sampled in cycle 0, LOAD is in cycle 1, RUN spans cycles 2 to 2+(2^CW-1-init), and done is in cycle 3+(2^CW-1-init).
REQ-020 An init value of all-ones SHALL produce exactly one RUN cycle, with done in cycle 3.
REQ-021 Abort: in LOAD or RUN, req[owner]=0 SHALL, at the edge, clear grant, enter IDLE, set last=owner, hold count, and give no done pulse.
REQ-022 Requests from non-owners during a job SHALL be ignored until IDLE; only req[owner] is observed while busy.
REQ-023 Re-arbitration SHALL occur only in IDLE, so back-to-back jobs are separated by one IDLE cycle.
REQ-024 Count SHALL hold its value in IDLE and DONE.
REQ-025 Grant SHALL never have more than one bit high.
REQ-026 Done and busy SHALL never be high while grant is zero, except for busy during the IDLE transition edge.

Reset
REQ-027 Reset high at a rising edge SHALL force state=IDLE, grant=0, owner=0, busy=0, done=0, count=0, and last=2, so requester 0 has first priority.
REQ-028 Reset SHALL override every other input, including mid-job in LOAD, RUN or DONE; no done pulse follows.
REQ-029 There SHALL be no asynchronous path and no reliance on initial blocks.

Structure
REQ-030 Shared package counter_arb_pkg SHALL hold the state enumeration, the IDLE/LOAD/RUN/DONE encodings, and the NREQ constant.
REQ-031 The block SHALL contain one sub-module, load_counter (CW-bit, with load, enable and a terminal-count flag), instantiated once as the shared resource.
REQ-032 The arbiter SHALL drive only the load, enable and data inputs of load_counter.

Verification
REQ-033 Reset, then req=001 with init0=4'hC: grant=001 in cycle 1, count runs C,D,E,F, done=1 in cycle 6, grant=0 in cycle 7.
REQ-034 req=111 held, all inits 4'hE: grant order SHALL be 001, 010, 100, 001, with each job lasting 4 busy cycles and one IDLE gap between jobs.
REQ-035 init1=4'hF with only req[1] high: exactly one RUN cycle, done in cycle 3.
REQ-036 Owner 2 with init2=0 drops req[2] when count=5: the next cycle is IDLE, grant=0, count holds 5, there is no done pulse, and a later req=101 grants 001.
REQ-037 Reset asserted for one cycle while in RUN with count=7: the next cycle shows all outputs zero and state IDLE, and a pending req=010 is granted in the cycle after reset deasserts.
REQ-038 Throughout all scenarios, assertions SHALL hold: grant one-hot or zero, done only while grant is nonzero, busy equal to (state != IDLE), and count never decreasing within a job.

Source files
------------

// File: rtl/counter_arb_pkg.sv
// Shared definitions for the counter arbiter: FSM state encoding, requester
// count and the round-robin pick helper.
package counter_arb_pkg;

  localparam int unsigned NREQ_C = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Returns {found, index}; the search starts at (last+1) mod NREQ_C.
  function automatic logic [2:0] rr_pick(input logic [NREQ_C-1:0] req,
                                         input logic [1:0]        last);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ_C; k++) begin
      cand = 2'((32'(last) + k) % NREQ_C);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/counter_arbiter_load_counter.sv
// Loadable up-counter with a terminal-count flag; the shared resource that
// the arbiter hands out to one requester at a time.
module load_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic          en_i,
  input  logic [CW-1:0] d_i,
  output logic [CW-1:0] q_o,
  output logic          tc_o
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] q_q;
  logic [CW-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (en_i) begin
      q_d = q_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o  = q_q;
  assign tc_o = &q_q;

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter granting a shared loadable counter to one of three
// requesters; each job loads the owner's init value and counts to all-ones.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int unsigned CW   = 4,
  parameter int unsigned NREQ = NREQ_C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [CW-1:0]   init0,
  input  logic [CW-1:0]   init1,
  input  logic [CW-1:0]   init2,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      owner,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   count
);

  state_e        state_q;
  state_e        state_d;
  logic [1:0]    owner_q;
  logic [1:0]    owner_d;
  logic [1:0]    last_q;
  logic [1:0]    last_d;
  logic          cnt_load;
  logic          cnt_en;
  logic [CW-1:0] init_sel;
  logic [CW-1:0] cnt_q;
  logic          cnt_tc;
  logic [2:0]    pick;
  logic          req_own;

  load_counter #(.CW(CW)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .load_i (cnt_load),
    .en_i   (cnt_en),
    .d_i    (init_sel),
    .q_o    (cnt_q),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    case (owner_q)
      2'd0:    init_sel = init0;
      2'd1:    init_sel = init1;
      default: init_sel = init2;
    endcase
  end

  assign pick    = rr_pick(req, last_q);
  assign req_own = req[owner_q];

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick[2]) begin
          owner_d = pick[1:0];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!req_own) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end else begin
          cnt_load = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Abort takes priority over completion; the count is left as-is.
        if (!req_own) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end else if (cnt_tc) begin
          state_d = S_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= 2'd2;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Grant is decoded from the registered state so it is one-hot by construction.
  always_comb begin
    grant = '0;
    if (state_q != S_IDLE) begin
      grant[owner_q] = 1'b1;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign count = cnt_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed-vector bench for counter_arbiter with a per-cycle invariant monitor.
module tb_counter_arbiter;
  import counter_arb_pkg::*;

  localparam int unsigned CW = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    req   = '0;
  logic [CW-1:0] init0 = '0;
  logic [CW-1:0] init1 = '0;
  logic [CW-1:0] init2 = '0;
  logic [2:0]    grant;
  logic [1:0]    owner;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic        mon_en   = 1'b0;
  state_e      prev_st  = S_IDLE;
  logic [CW-1:0] prev_cnt = '0;

  always #5 clk = ~clk;

  counter_arbiter #(.CW(CW), .NREQ(3)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .init0 (init0),
    .init1 (init1),
    .init2 (init2),
    .grant (grant),
    .owner (owner),
    .busy  (busy),
    .done  (done),
    .count (count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("gnt_onehot0", 32'($onehot0(grant)), 32'h1);
      chk("done_needs_gnt", 32'(done && (grant == '0)), 32'h0);
      chk("busy_vs_gnt", 32'(busy), 32'(grant != '0));
      if (prev_st == S_RUN && busy) begin
        chk("cnt_mono", 32'(count >= prev_cnt), 32'h1);
      end
      prev_st  <= dut.state_q;
      prev_cnt <= count;
    end
  end

  initial begin
    logic [2:0] exp_g [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_done",  32'(done),  32'h0);
    chk("rst_count", 32'(count), 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single job from requester 0, init C
    init0 = 4'hC;
    req   = 3'b001;
    tick();
    chk("s1_grant_c1", 32'(grant), 32'h1);
    chk("s1_owner_c1", 32'(owner), 32'h0);
    chk("s1_busy_c1",  32'(busy),  32'h1);
    for (int unsigned v = 12; v <= 15; v++) begin
      tick();
      chk("s1_count", 32'(count), v);
      chk("s1_nodone", 32'(done), 32'h0);
    end
    tick();
    chk("s1_done_c6",  32'(done),  32'h1);
    chk("s1_grant_c6", 32'(grant), 32'h1);
    chk("s1_count_c6", 32'(count), 32'hF);
    req = '0;
    tick();
    chk("s1_grant_c7", 32'(grant), 32'h0);
    chk("s1_done_c7",  32'(done),  32'h0);
    chk("s1_busy_c7",  32'(busy),  32'h0);
    chk("s1_count_c7", 32'(count), 32'hF);

    // All three requesting, round-robin order
    do_reset();
    init0 = 4'hE;
    init1 = 4'hE;
    init2 = 4'hE;
    req   = 3'b111;
    for (int unsigned j = 0; j < 4; j++) begin
      tick();
      chk("rr_grant_load", 32'(grant), 32'(exp_g[j]));
      tick();
      chk("rr_count_e", 32'(count), 32'hE);
      chk("rr_grant_run", 32'(grant), 32'(exp_g[j]));
      tick();
      chk("rr_count_f", 32'(count), 32'hF);
      chk("rr_nodone", 32'(done), 32'h0);
      tick();
      chk("rr_done", 32'(done), 32'h1);
      chk("rr_grant_done", 32'(grant), 32'(exp_g[j]));
      tick();
      chk("rr_gap_grant", 32'(grant), 32'h0);
      chk("rr_gap_busy",  32'(busy),  32'h0);
    end
    req = '0;

    // init all-ones: one RUN cycle, done in cycle 3
    do_reset();
    init1 = 4'hF;
    req   = 3'b010;
    tick();
    chk("s3_grant", 32'(grant), 32'h2);
    chk("s3_owner", 32'(owner), 32'h1);
    tick();
    chk("s3_count", 32'(count), 32'hF);
    chk("s3_nodone_c2", 32'(done), 32'h0);
    tick();
    chk("s3_done_c3", 32'(done), 32'h1);
    chk("s3_grant_c3", 32'(grant), 32'h2);
    req = '0;
    tick();
    chk("s3_idle_busy", 32'(busy), 32'h0);
    chk("s3_idle_done", 32'(done), 32'h0);

    // Owner 2 aborts at count 5
    do_reset();
    init2 = 4'h0;
    req   = 3'b100;
    tick();
    chk("s4_grant", 32'(grant), 32'h4);
    chk("s4_owner", 32'(owner), 32'h2);
    for (int unsigned v = 0; v <= 5; v++) begin
      tick();
      chk("s4_count", 32'(count), v);
    end
    req = 3'b000;
    tick();
    chk("s4_ab_grant", 32'(grant), 32'h0);
    chk("s4_ab_busy",  32'(busy),  32'h0);
    chk("s4_ab_done",  32'(done),  32'h0);
    chk("s4_ab_count", 32'(count), 32'h5);
    chk("s4_ab_owner", 32'(owner), 32'h2);
    req = 3'b101;
    tick();
    chk("s4_next_grant", 32'(grant), 32'h1);
    chk("s4_next_owner", 32'(owner), 32'h0);
    req = 3'b000;
    tick();
    chk("s4_ld_ab_grant", 32'(grant), 32'h0);
    chk("s4_ld_ab_count", 32'(count), 32'h5);
    chk("s4_ld_ab_done",  32'(done),  32'h0);

    // Reset mid-RUN at count 7, pending req=010
    do_reset();
    init0 = 4'h0;
    init1 = 4'h3;
    req   = 3'b001;
    tick();
    for (int unsigned v = 0; v <= 7; v++) begin
      tick();
      chk("s5_count", 32'(count), v);
    end
    reset = 1'b1;
    req   = 3'b010;
    tick();
    chk("s5_rst_grant", 32'(grant), 32'h0);
    chk("s5_rst_owner", 32'(owner), 32'h0);
    chk("s5_rst_busy",  32'(busy),  32'h0);
    chk("s5_rst_done",  32'(done),  32'h0);
    chk("s5_rst_count", 32'(count), 32'h0);
    reset = 1'b0;
    tick();
    chk("s5_grant", 32'(grant), 32'h2);
    chk("s5_owner", 32'(owner), 32'h1);
    tick();
    chk("s5_load", 32'(count), 32'h3);
    req = '0;
    tick();
    chk("s5_end_busy", 32'(busy), 32'h0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
